// File: rtl/if_id_queue.sv
// rtl/if_id_queue.sv - fetch-to-decode instruction queue with flush and optional bubble counter (IFQ_BUBBLE_CNT_EN)
module if_id_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h00003000
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       f_valid,
    input  logic [31:0]                f_instr,
    input  logic [31:0]                f_pc,
    output logic                       f_ready,
    input  logic                       d_ready,
    output logic                       d_valid,
    output logic [31:0]                d_instr,
    output logic [31:0]                d_pc,
    output logic [31:0]                d_pc8,
    input  logic                       flush,
    output logic [$clog2(DEPTH):0]     count,
    output logic [31:0]                bubble_cnt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [31:0]      instr_mem [DEPTH];
    logic [31:0]      pc_mem    [DEPTH];
    logic [PTR_W-1:0] rp;
    logic [PTR_W-1:0] wp;
    logic [CNT_W-1:0] cnt;
    logic             push;
    logic             pop;

    // Handshake decode; f_ready comes from cnt only so d_ready never reaches it.
    always_comb begin
        f_ready = (cnt != FULL_CNT);
        d_valid = (cnt != '0);
        push    = f_valid && f_ready && !flush;
        pop     = d_valid && d_ready && !flush;
    end

    // Entry storage; contents are meaningful only between rp and wp, so no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            instr_mem[wp] <= f_instr;
            pc_mem[wp]    <= f_pc;
        end
    end

    // Pointers and occupancy; flush wins over any same-cycle push or pop.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rp  <= '0;
            wp  <= '0;
            cnt <= '0;
        end else if (flush) begin
            rp  <= '0;
            wp  <= '0;
            cnt <= '0;
        end else begin
            if (push) wp <= wp + 1'b1;
            if (pop)  rp <= rp + 1'b1;
            case ({push, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Head view; an empty queue presents a nop at the reset PC.
    always_comb begin
        d_instr = 32'h00000000;
        d_pc    = RESET_PC;
        if (d_valid) begin
            d_instr = instr_mem[rp];
            d_pc    = pc_mem[rp];
        end
        d_pc8 = d_pc + 32'd8;
        count = cnt;
    end

`ifdef IFQ_BUBBLE_CNT_EN
    logic [31:0] bubble_q;

    // Counts cycles where decode wanted work but the queue was empty; saturates, survives flush.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bubble_q <= 32'd0;
        end else if (d_ready && !d_valid && !flush && (bubble_q != 32'hFFFFFFFF)) begin
            bubble_q <= bubble_q + 32'd1;
        end
    end

    assign bubble_cnt = bubble_q;
`else
    assign bubble_cnt = 32'd0;
`endif

endmodule

// File: doc/if_id_queue.md
IF_ID_QUEUE -- requirements
Module: if_id_queue

Interface
REQ-001 Parameter DEPTH, default 4, queue entries; SHALL be a power of two in 2..16.
REQ-002 Parameter RESET_PC, default 32'h00003000, PC reported on the empty-queue output.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset (asserted when 0).
REQ-005 f_valid  input  1  fetch stage presents an instruction this cycle.
REQ-006 f_instr  input  32  fetched instruction word.
REQ-007 f_pc  input  32  PC of f_instr.
REQ-008 f_ready  output  1  queue can accept a push this cycle.
REQ-009 d_ready  input  1  decode stage consumes head this cycle (deasserted on decode stall).
REQ-010 d_valid  output  1  head entry is valid.
REQ-011 d_instr  output  32  head instruction word.
REQ-012 d_pc  output  32  head PC.
REQ-013 d_pc8  output  32  head PC + 8, the link value for jal/jalr.
REQ-014 flush  input  1  discard all queued entries (redirect).
REQ-015 count  output  clog2(DEPTH)+1  number of valid entries.
REQ-016 bubble_cnt  output  32  decode bubble counter (see Configuration).

Function
REQ-017 Storage SHALL be DEPTH entries of {instr, pc}, with read pointer rp, write pointer wp, and count register cnt.
REQ-018 f_ready SHALL equal (cnt != DEPTH), depending on registered state only, with no combinational path from d_ready.
REQ-019 A push SHALL occur when f_valid && f_ready && !flush: write at wp, wp <= wp+1 mod DEPTH.
REQ-020 A pop SHALL occur when d_valid && d_ready && !flush: rp <= rp+1 mod DEPTH.
REQ-021 cnt SHALL update to cnt + push - pop, so a simultaneous push and pop leaves cnt unchanged.
REQ-022 d_valid SHALL equal (cnt != 0); d_instr/d_pc SHALL read the entry at rp combinationally.
REQ-023 Latency: an entry pushed at edge N SHALL appear on d_* after edge N (no same-cycle bypass).
REQ-024 When empty, d_instr SHALL be 32'h00000000 (nop), d_pc SHALL be RESET_PC, and d_pc8 SHALL be RESET_PC+8.
REQ-025 d_pc8 SHALL be d_pc + 32'd8 modulo 2^32.
REQ-026 When full, f_valid SHALL be ignored even if a pop occurs in the same cycle.
REQ-027 When empty, d_ready SHALL have no effect.
REQ-028 flush SHALL take precedence: at the next edge rp, wp, and cnt become 0, and any same-cycle push or pop is discarded.
REQ-029 Pointer wrap SHALL be silent; FIFO order SHALL be preserved across wrap.
REQ-030 Storage contents need not reset; only pointers and cnt define validity.

Reset
REQ-031 While reset == 0, rp, wp, and cnt SHALL clear to 0 immediately, independent of clk.
REQ-032 During reset the outputs SHALL be: f_ready=1, d_valid=0, d_instr=0, d_pc=RESET_PC, d_pc8=RESET_PC+8, count=0, bubble_cnt=0.
REQ-033 Reset asserted mid-operation SHALL drop all entries; the first push after release SHALL be accepted at the first rising edge with reset==1.

Configuration
REQ-034 Macro IFQ_BUBBLE_CNT_EN, when defined, SHALL enable a 32-bit bubble counter.
REQ-035 With the macro defined, the counter SHALL increment each cycle in which d_ready && !d_valid && !flush.
REQ-036 With the macro defined, the counter SHALL saturate at 32'hFFFFFFFF, be cleared only by reset (not by flush), and drive bubble_cnt.
REQ-037 Without the macro, no counter logic SHALL exist and bubble_cnt SHALL be tied to 0.

Verification
REQ-038 Reset release, then push pc 0x3000/0x3004/0x3008 on consecutive cycles with d_ready=1 -> d_pc sequence 0x3000, 0x3004, 0x3008 one cycle after each push; d_pc8 = 0x3008, 0x300C, 0x3010.
REQ-039 DEPTH=4, d_ready=0, push 5 times -> count=4 and f_ready=0 after the 4th push; the 5th entry is absent; d_pc is still the first PC.
REQ-040 Full queue, f_valid=1 and d_ready=1 in the same cycle -> only the pop occurs and count=3 at the next edge.
REQ-041 count=3, flush=1 with f_valid=1 and d_ready=1 -> next cycle count=0, d_valid=0, d_instr=0, d_pc=0x3000.
REQ-042 Push/pop 10 entries continuously at DEPTH=4 -> in-order output across two pointer wraps with no loss.
REQ-043 IFQ_BUBBLE_CNT_EN defined, d_ready=1 on an empty queue for 7 cycles, then flush -> bubble_cnt=7, unchanged by the flush; reset mid-run (reset=0 between edges) -> bubble_cnt=0 and count=0 immediately.
